// File: rtl/dma_seq_pkg.sv
// Shared types and constants for the DMA channel sequencer.
package dma_seq_pkg;

  localparam int unsigned NumCh  = 4;
  localparam int unsigned ChIdxW = $clog2(NumCh);

  // Strobe vector order: {memr_n, memw_n, ior_n, iow_n}
  localparam logic [3:0] StrobesOff = 4'b1111;

  typedef logic [ChIdxW-1:0] ch_idx_t;

  typedef enum logic [2:0] {
    StIdle,
    StHreq,
    StS1,
    StS2,
    StS3,
    StS4
  } dma_state_e;

endpackage

// File: rtl/dma_priority_encoder.sv
// Combinational channel arbiter: fixed (ch0 highest) or rotating from ptr_i.
module dma_priority_encoder
  import dma_seq_pkg::*;
(
  input  logic [NumCh-1:0] eligible_i,
  input  logic             rotate_i,
  input  ch_idx_t          ptr_i,
  output ch_idx_t          win_o,
  output logic             valid_o
);

  ch_idx_t base;
  ch_idx_t idx;
  logic    found;

  // Index arithmetic wraps naturally because NumCh is a power of two.
  always_comb begin
    base  = rotate_i ? ptr_i : '0;
    idx   = '0;
    win_o = '0;
    found = 1'b0;
    for (int unsigned i = 0; i < NumCh; i++) begin
      idx = base + ch_idx_t'(i);
      if (!found && eligible_i[idx]) begin
        win_o = idx;
        found = 1'b1;
      end
    end
  end

  assign valid_o = found;

endmodule

// File: rtl/dma_channel_sequencer.sv
// Four-channel single-transfer DMA sequencer with HRQ/HLDA bus handshake.
// Optional macro DMA_AUTOINIT_EN: reload current address/count from base on terminal count.
module dma_channel_sequencer
  import dma_seq_pkg::*;
#(
  parameter int unsigned NUM_CH = NumCh,
  parameter int unsigned ADDR_W = 16,
  parameter int unsigned CNT_W  = 16
) (
  input  logic              clk_i,
  input  logic              rst_ni,
  input  logic [NUM_CH-1:0] dreq_i,
  input  logic              hlda_i,
  input  logic              rotate_pri_i,
  input  logic [NUM_CH-1:0] dir_i,
  input  logic              wr_en_i,
  input  logic [1:0]        wr_chan_i,
  input  logic              wr_sel_i,
  input  logic [15:0]       wr_data_i,
  input  logic              mask_wr_i,
  input  logic [NUM_CH-1:0] mask_data_i,
  input  logic              status_clr_i,
  output logic              hrq_o,
  output logic              aen_o,
  output logic [ADDR_W-1:0] address_out_o,
  output logic [NUM_CH-1:0] dack_o,
  output logic              memr_n_o,
  output logic              memw_n_o,
  output logic              ior_n_o,
  output logic              iow_n_o,
  output logic              eop_o,
  output logic [NUM_CH-1:0] tc_status_o,
  output logic [NUM_CH-1:0] mask_o
);

  dma_state_e state_q, state_d;
  ch_idx_t    win_q, win_d;
  ch_idx_t    ptr_q, ptr_d;
  ch_idx_t    enc_win;
  logic       enc_valid;

  logic [NUM_CH-1:0] eligible;
  logic [NUM_CH-1:0] mask_q, mask_d;
  logic [NUM_CH-1:0] tc_q, tc_d;

  logic [ADDR_W-1:0] cur_addr_q [NUM_CH];
  logic [ADDR_W-1:0] cur_addr_d [NUM_CH];
  logic [CNT_W-1:0]  cur_cnt_q  [NUM_CH];
  logic [CNT_W-1:0]  cur_cnt_d  [NUM_CH];
`ifdef DMA_AUTOINIT_EN
  logic [ADDR_W-1:0] base_addr_q [NUM_CH];
  logic [ADDR_W-1:0] base_addr_d [NUM_CH];
  logic [CNT_W-1:0]  base_cnt_q  [NUM_CH];
  logic [CNT_W-1:0]  base_cnt_d  [NUM_CH];
`endif

  logic cfg_wr_ok;
  logic term_cnt;

  assign eligible  = dreq_i & ~mask_q;
  assign cfg_wr_ok = wr_en_i && (state_q == StIdle || state_q == StHreq);
  assign term_cnt  = (cur_cnt_q[win_q] == '0);

  dma_priority_encoder u_prio (
    .eligible_i (eligible),
    .rotate_i   (rotate_pri_i),
    .ptr_i      (ptr_q),
    .win_o      (enc_win),
    .valid_o    (enc_valid)
  );

  // State register
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q <= StIdle;
      win_q   <= '0;
    end else begin
      state_q <= state_d;
      win_q   <= win_d;
    end
  end

  // Next-state logic; the winner is frozen at grant so later dreq changes are ignored.
  always_comb begin
    state_d = state_q;
    win_d   = win_q;
    unique case (state_q)
      StIdle: if (enc_valid) state_d = StHreq;
      StHreq: begin
        if (!enc_valid) begin
          state_d = StIdle;
        end else if (hlda_i) begin
          state_d = StS1;
          win_d   = enc_win;
        end
      end
      StS1:    state_d = hlda_i ? StS2 : StIdle;
      StS2:    state_d = hlda_i ? StS3 : StIdle;
      StS3:    state_d = hlda_i ? StS4 : StIdle;
      StS4:    state_d = StIdle;
      default: state_d = StIdle;
    endcase
  end

  // Output decode
  always_comb begin
    hrq_o         = 1'b0;
    aen_o         = 1'b0;
    dack_o        = '0;
    address_out_o = '0;
    eop_o         = 1'b0;
    {memr_n_o, memw_n_o, ior_n_o, iow_n_o} = StrobesOff;
    unique case (state_q)
      StIdle: ;
      StHreq: hrq_o = 1'b1;
      StS1, StS2, StS3, StS4: begin
        hrq_o          = 1'b1;
        aen_o          = 1'b1;
        dack_o[win_q]  = 1'b1;
        address_out_o  = cur_addr_q[win_q];
        if (state_q == StS2 || state_q == StS3) begin
          if (dir_i[win_q]) memr_n_o = 1'b0;
          else              ior_n_o  = 1'b0;
        end
        if (state_q == StS3) begin
          if (dir_i[win_q]) iow_n_o  = 1'b0;
          else              memw_n_o = 1'b0;
        end
        if (state_q == StS4) eop_o = term_cnt;
      end
      default: ;
    endcase
  end

  // Register file, mask, status and rotation pointer next-state
  always_comb begin
    cur_addr_d = cur_addr_q;
    cur_cnt_d  = cur_cnt_q;
`ifdef DMA_AUTOINIT_EN
    base_addr_d = base_addr_q;
    base_cnt_d  = base_cnt_q;
`endif
    mask_d = mask_wr_i ? mask_data_i : mask_q;
    tc_d   = status_clr_i ? '0 : tc_q;
    ptr_d  = ptr_q;

    if (cfg_wr_ok) begin
      if (!wr_sel_i) begin
        cur_addr_d[wr_chan_i] = ADDR_W'(wr_data_i);
`ifdef DMA_AUTOINIT_EN
        base_addr_d[wr_chan_i] = ADDR_W'(wr_data_i);
`endif
      end else begin
        cur_cnt_d[wr_chan_i] = CNT_W'(wr_data_i);
`ifdef DMA_AUTOINIT_EN
        base_cnt_d[wr_chan_i] = CNT_W'(wr_data_i);
`endif
      end
    end

    if (state_q == StS4) begin
      ptr_d = win_q + ch_idx_t'(1);
      if (term_cnt) begin
        tc_d[win_q] = 1'b1;
`ifdef DMA_AUTOINIT_EN
        cur_addr_d[win_q] = base_addr_q[win_q];
        cur_cnt_d[win_q]  = base_cnt_q[win_q];
`else
        // Count stays at zero; the channel masks itself instead.
        cur_addr_d[win_q] = cur_addr_q[win_q] + ADDR_W'(1);
        mask_d[win_q]     = 1'b1;
`endif
      end else begin
        cur_addr_d[win_q] = cur_addr_q[win_q] + ADDR_W'(1);
        cur_cnt_d[win_q]  = cur_cnt_q[win_q] - CNT_W'(1);
      end
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      mask_q <= '1;
      tc_q   <= '0;
      ptr_q  <= '0;
      for (int unsigned i = 0; i < NUM_CH; i++) begin
        cur_addr_q[i] <= '0;
        cur_cnt_q[i]  <= '0;
`ifdef DMA_AUTOINIT_EN
        base_addr_q[i] <= '0;
        base_cnt_q[i]  <= '0;
`endif
      end
    end else begin
      mask_q     <= mask_d;
      tc_q       <= tc_d;
      ptr_q      <= ptr_d;
      cur_addr_q <= cur_addr_d;
      cur_cnt_q  <= cur_cnt_d;
`ifdef DMA_AUTOINIT_EN
      base_addr_q <= base_addr_d;
      base_cnt_q  <= base_cnt_d;
`endif
    end
  end

  assign mask_o      = mask_q;
  assign tc_status_o = tc_q;

endmodule

// File: tb/tb_dma_channel_sequencer.sv
// Scoreboard bench for dma_channel_sequencer: driver predicts each transfer, monitor checks it.
module tb_dma_channel_sequencer;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic [3:0]  dreq = '0, dir = '0, mask_data = '0;
  logic        hlda = 1'b0, rotate_pri = 1'b0, wr_en = 1'b0, wr_sel = 1'b0;
  logic        mask_wr = 1'b0, status_clr = 1'b0;
  logic [1:0]  wr_chan = '0;
  logic [15:0] wr_data = '0;

  logic        hrq, aen, memr_n, memw_n, ior_n, iow_n, eop;
  logic [15:0] address_out;
  logic [3:0]  dack, tc_status, mask;

  dma_channel_sequencer dut (
    .clk_i         (clk),
    .rst_ni        (rst_n),
    .dreq_i        (dreq),
    .hlda_i        (hlda),
    .rotate_pri_i  (rotate_pri),
    .dir_i         (dir),
    .wr_en_i       (wr_en),
    .wr_chan_i     (wr_chan),
    .wr_sel_i      (wr_sel),
    .wr_data_i     (wr_data),
    .mask_wr_i     (mask_wr),
    .mask_data_i   (mask_data),
    .status_clr_i  (status_clr),
    .hrq_o         (hrq),
    .aen_o         (aen),
    .address_out_o (address_out),
    .dack_o        (dack),
    .memr_n_o      (memr_n),
    .memw_n_o      (memw_n),
    .ior_n_o       (ior_n),
    .iow_n_o       (iow_n),
    .eop_o         (eop),
    .tc_status_o   (tc_status),
    .mask_o        (mask)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_errors = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  // Expected outcome of one bus transfer
  typedef struct {
    logic [3:0]  dack;
    logic [15:0] addr;
    logic        dir;
    logic        wr;
    int          eops;
    logic [3:0]  mask;
    logic [3:0]  tc;
  } exp_t;

  exp_t sb[$];

  // Reference model: channel registers as plain arrays
  logic [15:0] m_addr[4], m_cnt[4], m_baddr[4], m_bcnt[4];
  logic [3:0]  m_mask, m_tc;
  int          m_ptr;

  function automatic void model_reset();
    for (int i = 0; i < 4; i++) begin
      m_addr[i] = '0; m_cnt[i] = '0; m_baddr[i] = '0; m_bcnt[i] = '0;
    end
    m_mask = 4'hF;
    m_tc   = 4'h0;
    m_ptr  = 0;
  endfunction

  function automatic int pick(input logic [3:0] el);
    for (int k = 0; k < 4; k++) begin
      int c;
      c = rotate_pri ? (m_ptr + k) % 4 : k;
      if (el[c]) return c;
    end
    return -1;
  endfunction

  function automatic void model_complete(input int w);
    if (m_cnt[w] == 16'd0) begin
      m_tc[w] = 1'b1;
`ifdef DMA_AUTOINIT_EN
      m_addr[w] = m_baddr[w];
      m_cnt[w]  = m_bcnt[w];
`else
      m_addr[w] = m_addr[w] + 16'd1;
      m_mask[w] = 1'b1;
`endif
    end else begin
      m_addr[w] = m_addr[w] + 16'd1;
      m_cnt[w]  = m_cnt[w] - 16'd1;
    end
    m_ptr = (w + 1) % 4;
  endfunction

  task automatic check_reset(input string p);
    check({p, "_hrq"},     32'(hrq), 32'd0);
    check({p, "_aen"},     32'(aen), 32'd0);
    check({p, "_addr"},    32'(address_out), 32'd0);
    check({p, "_dack"},    32'(dack), 32'd0);
    check({p, "_strobes"}, 32'({memr_n, memw_n, ior_n, iow_n}), 32'hF);
    check({p, "_eop"},     32'(eop), 32'd0);
    check({p, "_tc"},      32'(tc_status), 32'd0);
    check({p, "_mask"},    32'(mask), 32'hF);
  endtask

  task automatic do_reset();
    rst_n = 1'b0; dreq = '0; hlda = 1'b0; wr_en = 1'b0; mask_wr = 1'b0; status_clr = 1'b0;
    model_reset();
    @(negedge clk);
    check_reset("rst");
    rst_n = 1'b1;
    @(negedge clk);
  endtask

  task automatic go_idle();
    dreq = '0;
    hlda = 1'b0;
    repeat (3) @(negedge clk);
  endtask

  task automatic write_reg(input int ch, input bit sel, input logic [15:0] data);
    wr_en = 1'b1; wr_chan = 2'(ch); wr_sel = sel; wr_data = data;
    if (!sel) begin m_addr[ch] = data; m_baddr[ch] = data; end
    else      begin m_cnt[ch]  = data; m_bcnt[ch]  = data; end
    @(negedge clk);
    wr_en = 1'b0;
  endtask

  task automatic mask_write(input logic [3:0] d);
    mask_wr = 1'b1; mask_data = d; m_mask = d;
    @(negedge clk);
    mask_wr = 1'b0;
  endtask

  // mode: 0 normal, 1 hlda drop in S2, 2 reset in S3, 3 write during S1, 4 status_clr held
  task automatic do_xfer(input int mode);
    exp_t e;
    int   w;
    bit   seen;
    bit   full;
    seen = 1'b0;
    for (int i = 0; i < 20 && !seen; i++) begin
      @(negedge clk);
      seen = hrq;
    end
    if (!seen) begin
      check("hrq_wait", 32'(hrq), 32'd1);
      return;
    end
    w = pick(dreq & ~m_mask);
    if (w < 0) begin
      check("model_eligible", 32'(dreq & ~m_mask), 32'd1);
      return;
    end
    full   = (mode == 0 || mode == 3 || mode == 4);
    e.dack = 4'(1 << w);
    e.addr = m_addr[w];
    e.dir  = dir[w];
    e.wr   = (mode != 1);
    e.eops = (full && m_cnt[w] == 16'd0) ? 1 : 0;
    if (full) begin
      if (mode == 4) m_tc = 4'h0;
      model_complete(w);
    end
    if (mode == 2) model_reset();
    e.mask = m_mask;
    e.tc   = m_tc;
    sb.push_back(e);

    hlda = 1'b1;
    if (mode == 4) status_clr = 1'b1;
    @(negedge clk);  // S1
    if (mode == 3) begin
      wr_en = 1'b1; wr_chan = 2'(w); wr_sel = 1'b0; wr_data = 16'h5555;
    end
    @(negedge clk);  // S2
    wr_en = 1'b0;
    if (mode == 1) begin
      check("s2_read", 32'({memr_n, ior_n}), 32'(dir[w] ? 2'b01 : 2'b10));
      hlda = 1'b0;
      @(negedge clk);
      check("abort_strobes", 32'({memr_n, memw_n, ior_n, iow_n}), 32'hF);
      check("abort_aen", 32'(aen), 32'd0);
      check("abort_dack", 32'(dack), 32'd0);
      check("abort_hrq", 32'(hrq), 32'd0);
      return;
    end
    @(negedge clk);  // S3
    if (mode == 2) begin
      #1 rst_n = 1'b0;
      #1 check_reset("s3rst");
      @(negedge clk);
      hlda = 1'b0; dreq = '0;
      @(negedge clk);
      rst_n = 1'b1;
      @(negedge clk);
      return;
    end
    seen = 1'b0;
    for (int i = 0; i < 10 && !seen; i++) begin
      @(negedge clk);
      seen = !hrq;
    end
    if (!seen) check("hrq_release", 32'(hrq), 32'd0);
    hlda = 1'b0;
    status_clr = 1'b0;
  endtask

  // Monitor: collects one transfer per aen window and compares it with the scoreboard head
  initial begin
    bit          in_xfer;
    logic [3:0]  c_dack, seen_st, exp_st;
    logic [15:0] c_addr;
    int          c_eops;
    exp_t        e;
    in_xfer = 1'b0;
    forever begin
      @(negedge clk);
      if (aen) begin
        if (!in_xfer) begin
          in_xfer = 1'b1;
          c_dack  = dack;
          c_addr  = address_out;
          seen_st = '0;
          c_eops  = 0;
        end
        seen_st |= {~memr_n, ~ior_n, ~memw_n, ~iow_n};
        if (eop) c_eops++;
      end else if (in_xfer) begin
        in_xfer = 1'b0;
        check("sb_nonempty", 32'(sb.size() != 0), 32'd1);
        if (sb.size() != 0) begin
          e = sb.pop_front();
          exp_st = {e.dir, ~e.dir, ~e.dir & e.wr, e.dir & e.wr};
          check("mon_dack", 32'(c_dack), 32'(e.dack));
          check("mon_addr", 32'(c_addr), 32'(e.addr));
          check("mon_strobes", 32'(seen_st), 32'(exp_st));
          check("mon_eop", 32'(c_eops), 32'(e.eops));
          check("mon_mask", 32'(mask), 32'(e.mask));
          check("mon_tc", 32'(tc_status), 32'(e.tc));
        end
      end
    end
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: run did not complete, errors so far %0d", n_errors);
    $fatal(1, "watchdog expired");
  end

  initial begin
    model_reset();
    @(negedge clk);
    do_reset();

    // Three transfers on ch1 ending in terminal count
    write_reg(1, 1'b0, 16'h0100);
    write_reg(1, 1'b1, 16'h0002);
    mask_write(4'b1101);
    dir  = 4'b0010;
    dreq = 4'b0010;
    repeat (3) do_xfer(0);
    check("t1_tc", 32'(tc_status), 32'h2);
    go_idle();

    // Fixed priority: ch0 always wins
    do_reset();
    for (int c = 0; c < 4; c++) begin
      write_reg(c, 1'b0, 16'(c * 16'h1000));
      write_reg(c, 1'b1, 16'h0010);
    end
    mask_write(4'h0);
    rotate_pri = 1'b0;
    dir  = 4'b0101;
    dreq = 4'hF;
    repeat (3) do_xfer(0);
    go_idle();

    // Rotating priority: 0,1,2,3,0
    do_reset();
    for (int c = 0; c < 4; c++) begin
      write_reg(c, 1'b0, 16'(c * 16'h1000));
      write_reg(c, 1'b1, 16'h0010);
    end
    mask_write(4'h0);
    rotate_pri = 1'b1;
    dreq = 4'hF;
    repeat (5) do_xfer(0);
    go_idle();

    // Address wrap FFFF -> 0000 with terminal count on the second transfer
    rotate_pri = 1'b0;
    write_reg(2, 1'b0, 16'hFFFF);
    write_reg(2, 1'b1, 16'h0001);
    mask_write(4'b1011);
    dreq = 4'b0100;
    repeat (2) do_xfer(0);
    go_idle();

    // Abort in S2, then write dropped mid-transfer, then status_clr racing TC
    write_reg(3, 1'b0, 16'h3000);
    write_reg(3, 1'b1, 16'h0005);
    mask_write(4'b0111);
    dir  = 4'b1000;
    dreq = 4'b1000;
    do_xfer(1);
    do_xfer(0);
    do_xfer(3);
    do_xfer(0);
    go_idle();
    write_reg(3, 1'b1, 16'h0000);
    mask_write(4'b0111);
    dreq = 4'b1000;
    do_xfer(4);
    go_idle();

    // Randomised traffic
    for (int it = 0; it < 150; it++) begin
      if ($urandom_range(0, 3) == 0) begin
        go_idle();
        write_reg($urandom_range(0, 3), 1'b0, 16'($urandom));
        write_reg($urandom_range(0, 3), 1'b1, 16'($urandom_range(0, 3)));
        mask_write(4'($urandom));
        rotate_pri = 1'($urandom);
        dir = 4'($urandom);
      end
      dreq = 4'($urandom_range(1, 15));
      if ((dreq & ~m_mask) == 4'h0) mask_write(4'($urandom) & ~dreq);
      do_xfer(0);
    end
    go_idle();

    // Async reset in the middle of S3, then a clean transfer afterwards
    write_reg(0, 1'b0, 16'h0A00);
    write_reg(0, 1'b1, 16'h0005);
    mask_write(4'h0);
    dreq = 4'b0001;
    do_xfer(2);
    write_reg(0, 1'b0, 16'h0B00);
    write_reg(0, 1'b1, 16'h0003);
    mask_write(4'h0);
    dreq = 4'b0001;
    do_xfer(0);
    go_idle();

    repeat (3) @(negedge clk);
    check("sb_empty", 32'(sb.size()), 32'd0);
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule

// File: doc/dma_channel_sequencer.md
Name: dma_channel_sequencer

Overview:
- Four-channel DMA timing and priority controller, single-transfer mode.
- Arbitrates DREQ lines and handshakes the bus with the CPU via HRQ/HLDA.
- Drives AEN and the 16-bit transfer address into the IO address buffer.
- Generates DACK, active-low read/write strobes and terminal-count/EOP.

Parameters:
NUM_CH, 4, number of DMA channels; fixed at 4 in this revision.
ADDR_W, 16, address register width; must match the IO buffer.
CNT_W, 16, word-count register width.

Ports:
clk  input  1  system clock, rising edge
Reset  input  1  asynchronous, active-low reset
dreq  input  NUM_CH  per-channel DMA request, active-high, level
hlda  input  1  CPU hold acknowledge
rotate_pri  input  1  0 = fixed priority (ch0 highest), 1 = rotating priority
dir  input  NUM_CH  per-channel direction: 1 = memory->IO, 0 = IO->memory
wr_en  input  1  register write strobe, one cycle
wr_chan  input  2  target channel of the register write
wr_sel  input  1  0 = base/current address, 1 = base/current count
wr_data  input  16  write data
mask_wr  input  1  load mask register from mask_data
mask_data  input  NUM_CH  new mask value (1 = channel masked)
status_clr  input  1  clears tc_status
hrq  output  1  hold request to CPU
aen  output  1  address enable to IO buffer / address bus
address_out  output  ADDR_W  current transfer address, to IO buffer address_in
dack  output  NUM_CH  one-hot acknowledge of the served channel
memr_n, memw_n, ior_n, iow_n  output  1 each  active-low bus strobes
eop  output  1  one-cycle pulse on terminal count
tc_status  output  NUM_CH  sticky per-channel terminal-count flags
mask  output  NUM_CH  current mask register

Behaviour:
- Reset (async, Reset=0): state IDLE; hrq=0, aen=0, dack=0, all strobes=1, eop=0, address_out=0, tc_status=0, mask=all 1s, all address/count registers=0, rotation pointer=ch0 highest.
- Register writes:
  - wr_en loads both base and current of the selected register.
  - Accepted only in IDLE or HREQ; silently dropped in S1–S4.
- Mask register:
  - mask_wr is accepted in any state.
  - In S4, the auto-mask bit for a terminal-count channel is ORed over the mask_data value.
- Eligible channel: dreq[i] & ~mask[i].
- FSM:
  - IDLE: any channel eligible -> HREQ, hrq=1.
  - HREQ: hold hrq=1.
    - If no channel is eligible -> IDLE, hrq=0.
    - Else if hlda=1 -> latch the arbitration winner -> S1.
  - S1: aen=1, address_out=current address of winner, dack[win]=1.
  - S2: read strobe asserted (memr_n if dir=1, else ior_n).
  - S3: read strobe held; write strobe asserted (iow_n if dir=1, else memw_n).
  - S4:
    - All strobes deassert.
    - Current address +1 (wraps FFFF->0000).
    - If current count==0: eop=1, tc_status[win]=1, mask[win]=1. Count is not decremented.
    - Otherwise count -1.
    - Next state IDLE: hrq, aen, dack cleared on entry to IDLE.
- Latency: minimum 2 cycles from dreq to hrq-asserted-with-grant; a transfer occupies S1–S4 (4 cycles).
- Arbitration:
  - Fixed mode: lowest index wins.
  - Rotating mode: the channel served in S4 becomes lowest priority for the next arbitration.
- hlda drops in S1–S3: abort to IDLE; strobes, dack, aen released next cycle; no address/count update.
- dreq drops after grant: the transfer completes (dreq is sampled only in HREQ).
- status_clr and a simultaneous TC: TC set wins for that bit.

Optional Feature:
- Macro: DMA_AUTOINIT_EN.
- Defined: on terminal count, current address/count reload from base, mask[win] is not set, and eop and tc_status still assert.
- Undefined: auto-mask behaviour as above; base registers are write-only shadows.

Decomposition:
- Package dma_seq_pkg: state enum (IDLE, HREQ, S1, S2, S3, S4), NUM_CH, channel index width, strobe-inactive constant.
- Sub-module dma_priority_encoder: combinational fixed/rotating winner from the eligible vector and rotation pointer. Outputs winner index and a valid flag.

Test Plan:
- Program ch1 addr=0x0100, count=0x0002; unmask ch1; dreq[1]=1, hlda follows hrq by 1 cycle -> three transfers at addresses 0x0100, 0x0101, 0x0102. eop on the third; tc_status=0010; mask[1]=1.
- dreq=1111, all unmasked, rotate_pri=0, repeated grants -> ch0 served every time.
- Same stimulus with rotate_pri=1 -> service order 0,1,2,3,0.
- Current addr=0xFFFF, count=1 -> address_out 0xFFFF then 0x0000 on the next transfer; eop on the second.
- hlda deasserted in S2 -> strobes high, aen=0, dack=0 next cycle; address and count unchanged.
- Async Reset low mid-S3 -> all outputs at reset values within the same cycle; mask=1111.
